// File: rtl/alu_nbit_seq_pkg.sv
// Shared opcode, flag-index and FSM definitions for the sequential ALU and its multiplier.
package alu_nbit_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;
    localparam logic [2:0] OP_ADC = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam int F_Z = 3;
    localparam int F_C = 2;
    localparam int F_V = 1;
    localparam int F_N = 0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    function automatic logic [3:0] pack_flags(input logic z, input logic c,
                                              input logic v, input logic n);
        logic [3:0] f;
        f      = '0;
        f[F_Z] = z;
        f[F_C] = c;
        f[F_V] = v;
        f[F_N] = n;
        return f;
    endfunction

endpackage

// File: rtl/alu_nbit_seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
module alu_nbit_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] prod_o
);
    localparam int CW = $clog2(WIDTH + 1);

    logic               busy_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mplier_q;
    logic [WIDTH:0]     partial;

    // Accumulator shifts right; the upper half collects the running sum of partial products.
    always_comb begin
        partial = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_d   = {partial, acc_q[WIDTH-1:1]};
    end

    assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign busy_o = busy_q;
    // The product is presented on the final step so the top can load it on that same edge.
    assign prod_o = acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mplier_q <= mplier_q >> 1;
            if (done_o) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_nbit_seq.sv
// Registered N-bit ALU with in/out valid-ready handshakes, carry chaining (ADC) and iterative MUL.
module alu_nbit_seq
    import alu_nbit_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);
    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic               carry_q, carry_d;

    logic               accept, mul_start, mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH:0]     sum, diff, cin_ext;
    logic [WIDTH-1:0]   alu_res, mul_res;
    logic [3:0]         alu_flags, mul_flags;
    logic               c, v, z, n, mul_hi;

    assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (opcode == OP_MUL);

    alu_nbit_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start_i (mul_start),
        .a_i     (a),
        .b_i     (b),
        .busy_o  (mul_busy),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    // Single-cycle datapath, WIDTH+1 bits so the top bit is carry-out / borrow.
    always_comb begin
        cin_ext = {{WIDTH{1'b0}}, carry_q && (opcode == OP_ADC)};
        sum     = {1'b0, a} + {1'b0, b} + cin_ext;
        diff    = {1'b0, a} - {1'b0, b};
        alu_res = '0;
        c       = 1'b0;
        v       = 1'b0;
        unique case (opcode)
            OP_ADD, OP_ADC: begin
                alu_res = sum[WIDTH-1:0];
                c       = sum[WIDTH];
                v       = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = (opcode == OP_SUB) ? diff[WIDTH-1:0] : '0;
                c       = diff[WIDTH];
                v       = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            default: alu_res = '0;
        endcase
        z         = (opcode == OP_CMP) ? (a == b) : (alu_res == '0);
        n         = (opcode == OP_CMP) ? diff[WIDTH-1] : alu_res[WIDTH-1];
        alu_flags = pack_flags(z, c, v, n);
    end

    always_comb begin
        mul_res   = mul_prod[WIDTH-1:0];
        mul_hi    = |mul_prod[2*WIDTH-1:WIDTH];
        mul_flags = pack_flags(mul_res == '0, mul_hi, mul_hi, mul_res[WIDTH-1]);
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        carry_d     = carry_q;
        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (opcode == OP_MUL) begin
                        state_d = S_BUSY;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        flags_d     = alu_flags;
                        carry_d     = alu_flags[F_C];
                    end
                end
            end
            S_BUSY: begin
                if (mul_done) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = mul_res;
                    flags_d     = mul_flags;
                    carry_d     = mul_flags[F_C];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            carry_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            carry_q     <= carry_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule
